// File: rtl/sync_tx.sv
// rtl/sync_tx.sv - sync field + NRZI/bit-stuffed payload transmitter with SE0 end-of-packet
module sync_tx #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  input  logic              err_inj,
  output logic              k,
  output logic              j,
  output logic              tx_en,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP} state_t;

  localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);

  state_t            state, state_d;
  logic [5:0]        cnt, cnt_d;
  logic [2:0]        ones, ones_d;
  logic [DATA_W-1:0] sh, sh_d;
  logic              err_q, err_d;
  logic              k_d, j_d, tx_en_d, done_d;
  logic              load_bit;

  // State and counters describe the symbol currently on the lines; every
  // output is computed one cycle ahead and registered.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    ones_d   = ones;
    sh_d     = sh;
    err_d    = err_q;
    k_d      = 1'b0;
    j_d      = 1'b0;
    tx_en_d  = 1'b0;
    done_d   = 1'b0;
    load_bit = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d = SYNC;
          cnt_d   = '0;
          ones_d  = '0;
          sh_d    = data;
          err_d   = err_inj;
          k_d     = 1'b1;
          tx_en_d = 1'b1;
        end
      end
      SYNC: begin
        tx_en_d = 1'b1;
        if (cnt == 6'd7) begin
          load_bit = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt + 6'd1;
          if (cnt == 6'd6) begin
            k_d = ~err_q;
            j_d = err_q;
          end else begin
            k_d = cnt[0];
            j_d = ~cnt[0];
          end
        end
      end
      DATA: begin
        tx_en_d = 1'b1;
        if (ones == 3'd6) begin
          state_d = STUFF;
          j_d     = ~j;
          k_d     = j;
          ones_d  = '0;
        end else if (cnt == LAST_BIT) begin
          state_d = EOP;
          cnt_d   = '0;
        end else begin
          load_bit = 1'b1;
          cnt_d    = cnt + 6'd1;
        end
      end
      STUFF: begin
        tx_en_d = 1'b1;
        if (cnt == LAST_BIT) begin
          state_d = EOP;
          cnt_d   = '0;
        end else begin
          load_bit = 1'b1;
          cnt_d    = cnt + 6'd1;
        end
      end
      EOP: begin
        if (cnt == 6'd0) begin
          cnt_d   = 6'd1;
          tx_en_d = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // NRZI reference is the level already on j, so corrupted sync carries over.
    if (load_bit) begin
      state_d = DATA;
      tx_en_d = 1'b1;
      j_d     = sh[0] ? j : ~j;
      k_d     = sh[0] ? k : ~k;
      ones_d  = sh[0] ? ones + 3'd1 : 3'd0;
      sh_d    = sh >> 1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
      ones  <= '0;
      sh    <= '0;
      err_q <= 1'b0;
      k     <= 1'b0;
      j     <= 1'b0;
      tx_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      ones  <= ones_d;
      sh    <= sh_d;
      err_q <= err_d;
      k     <= k_d;
      j     <= j_d;
      tx_en <= tx_en_d;
      busy  <= (state_d != IDLE);
      done  <= done_d;
    end
  end

endmodule

// File: tb/tb_sync_tx.sv
// tb/tb_sync_tx.sv - self-checking bench for sync_tx against a symbol-level frame model
module tb_sync_tx;
  localparam int W = 8;
  // Symbols as {tx_en, j, k}
  localparam logic [2:0] SK = 3'b101;
  localparam logic [2:0] SJ = 3'b110;
  localparam logic [2:0] SE = 3'b100;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         start = 1'b0;
  logic         err_inj = 1'b0;
  logic [W-1:0] data = '0;
  logic         k, j, tx_en, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  sync_tx #(.DATA_W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .data(data), .err_inj(err_inj),
    .k(k), .j(j), .tx_en(tx_en), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Frame from the line rules: sync, NRZI data with a stuffed toggle after six ones, two SE0.
  task automatic model(input logic [W-1:0] d, input logic e);
    logic lvl;
    int   n1;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back((i % 2 == 1) ? SJ : SK);
    exp_q.push_back(e ? SJ : SK);
    lvl = e;
    n1  = 0;
    for (int i = 0; i < W; i++) begin
      if (d[i]) n1++;
      else begin
        lvl = ~lvl;
        n1  = 0;
      end
      exp_q.push_back(lvl ? SJ : SK);
      if (n1 == 6) begin
        lvl = ~lvl;
        n1  = 0;
        exp_q.push_back(lvl ? SJ : SK);
      end
    end
    exp_q.push_back(SE);
    exp_q.push_back(SE);
  endtask

  task automatic from_string(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "K") exp_q.push_back(SK);
      else if (s[i] == "J") exp_q.push_back(SJ);
      else exp_q.push_back(SE);
    end
  endtask

  // Called at a negedge; start is raised immediately so a call in the done cycle is back-to-back.
  task automatic send_frame(input string tag, input logic [W-1:0] d, input logic e,
                            input string golden, input bit dup_start);
    if (golden.len() > 0) from_string(golden);
    else model(d, e);
    data    = d;
    err_inj = e;
    start   = 1'b1;
    @(negedge CLK);
    start   = 1'b0;
    data    = W'($urandom);
    err_inj = 1'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge CLK);
      if (dup_start) start = (i == 4);
      check({tag, "_sym"}, 32'({tx_en, j, k}), 32'(exp_q[i]));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
    end
    @(negedge CLK);
    check({tag, "_done"}, 32'({done, busy, tx_en}), 32'b100);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic         re;

    repeat (3) @(negedge CLK);
    check("reset_outputs", 32'({k, j, tx_en, busy, done}), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_outputs", 32'({k, j, tx_en, busy, done}), 32'd0);

    send_frame("p00", 8'h00, 1'b0, "KJKJKJKKJKJKJKJKEE", 1'b0);
    @(negedge CLK);
    send_frame("pff", 8'hFF, 1'b0, "KJKJKJKKKKKKKKJJJEE", 1'b0);
    send_frame("p3f_b2b", 8'h3F, 1'b0, "KJKJKJKKKKKKKKJKJEE", 1'b0);
    @(negedge CLK);
    send_frame("err00", 8'h00, 1'b1, "KJKJKJKJKJKJKJKJEE", 1'b0);
    @(negedge CLK);
    send_frame("dup", 8'hA5, 1'b0, "", 1'b1);
    repeat (12) begin
      @(negedge CLK);
      check("dup_not_queued", 32'({busy, tx_en, done}), 32'd0);
    end

    for (int n = 0; n < 24; n++) begin
      rd = W'($urandom);
      re = ($urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      send_frame("rand", rd, re, "", 1'b0);
    end
    send_frame("stuff_last", 8'hFC, 1'b0, "", 1'b0);

    @(negedge CLK);
    data  = 8'h5A;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (12) @(negedge CLK);
    check("pre_reset_active", 32'({tx_en, busy}), 32'b11);
    #2 RST = 1'b0;
    #1 check("async_reset", 32'({k, j, tx_en, busy, done}), 32'd0);
    repeat (2) begin
      @(negedge CLK);
      check("held_reset", 32'({k, j, tx_en, busy, done}), 32'd0);
    end
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      check("post_reset_idle", 32'({busy, tx_en, done}), 32'd0);
    end
    send_frame("after_rst", 8'h5A, 1'b0, "", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_tx.md
# sync_tx

Sync-pattern and payload transmitter that drives the `k`/`j`/`rx_en` symbol interface consumed by the sync-detecting receiver (`circuito12`). It produces the eight-symbol `KJKJKJKK` sync field, then a `DATA_W`-bit payload sent LSB-first. The payload is NRZI-encoded with bit stuffing and closed by a two-symbol SE0 end-of-packet. It is the stimulus source for functional and BIST bring-up of the receiver. Its error-injection input deliberately corrupts the sync field so the receiver's `sync_err_d` path can be exercised.

## Interface
- `DATA_W`, default 8: payload width in bits, range 1..32.
- `CLK`  input  1: single clock; all state changes on the rising edge.
- `RST`  input  1: asynchronous, active-low reset.
- `start`  input  1: transmit request, sampled only while `busy`=0.
- `data`  input  DATA_W: payload, latched in the cycle `start` is accepted.
- `err_inj`  input  1: latched with `start`; corrupts the eighth sync symbol.
- `k`  output  1: K line level (registered).
- `j`  output  1: J line level (registered).
- `tx_en`  output  1: frame-valid qualifier; connects to the receiver's `rx_en` (registered).
- `busy`  output  1: high while a frame is in progress.
- `done`  output  1: one-cycle pulse after the last EOP symbol.

## Operation
- Symbol encoding:
  - J = (`j`=1, `k`=0).
  - K = (`j`=0, `k`=1).
  - SE0 = (`j`=0, `k`=0).
  - Idle = SE0 with `tx_en`=0.
- FSM states: IDLE, SYNC, DATA, STUFF, EOP.
- IDLE:
  - Outputs idle.
  - `start`=1 latches `data` and `err_inj`, clears the symbol and ones counters, and moves to SYNC.
- SYNC:
  - Drives `K J K J K J K K` on eight consecutive cycles with `tx_en`=1.
  - If the latched `err_inj`=1, symbol 8 is driven as J instead of K.
  - Then moves to DATA.
- DATA:
  - Sends one payload bit per cycle, LSB first.
  - NRZI rule: bit 0 toggles the line (J↔K) relative to the previous driven symbol; bit 1 repeats it.
  - The NRZI reference is the actually driven last sync symbol, so it follows any `err_inj` corruption.
  - The ones counter (3 bits) increments on every 1 and clears on every 0.
  - When the counter reaches 6, the next cycle goes to STUFF before the next data bit. This also applies when the 6th one is the last payload bit.
- STUFF:
  - Drives one toggled symbol (a stuffed 0) and clears the ones counter.
  - Returns to DATA if payload bits remain, otherwise goes to EOP.
- EOP:
  - Two cycles of SE0 with `tx_en`=1, then IDLE.
- `start` while `busy`=1 is ignored and not queued.
- Changes to `data` or `err_inj` after acceptance have no effect on the frame in progress.

## Timing
- Reset values:
  - `k`=0, `j`=0, `tx_en`=0, `busy`=0, `done`=0.
  - FSM in IDLE, counters 0.
- `start` accepted at edge n:
  - First sync symbol and `busy`=1 appear after edge n, during cycle n+1.
  - Sync occupies cycles n+1..n+8.
  - Data occupies n+9 .. n+8+DATA_W+S, where S is the number of stuffed symbols.
  - EOP occupies the following two cycles.
- In the cycle after the last EOP symbol:
  - `done`=1 for exactly one cycle.
  - `busy`=0, `tx_en`=0.
- A `start` in the `done` cycle is accepted, giving back-to-back frames with exactly one idle cycle between them.
- Frame length is 8 + DATA_W + S + 2 cycles, with S ≤ floor(DATA_W/6).
- `RST` asserted mid-frame:
  - All outputs go to reset values immediately (asynchronous).
  - No `done` pulse is produced.
  - The frame is abandoned; after release the block is in IDLE.
- No combinational path from any input to any output.

## Test plan
- Payload 0x00, `err_inj`=0, `start` at n:
  - Cycles n+1..n+8 carry KJKJKJKK.
  - n+9..n+16 carry J,K,J,K,J,K,J,K.
  - n+17..n+18 carry SE0 with `tx_en`=1.
  - `done` pulses at n+19.
- Payload 0xFF:
  - Data phase is K×6, stuffed J, J, J (9 cycles).
  - EOP at n+18..n+19; `done` at n+20.
- Payload 0x3F (six ones, then two zeros): K×6, stuffed J, then K, J; `done` at n+20.
- `err_inj`=1 with payload 0x00:
  - Sync field is KJKJKJKJ.
  - Data is K,J,K,J,K,J,K,J.
  - Receiver `sync_err_d` asserts; `synced_d` does not assert.
- Second `start` pulse during cycle n+5 is ignored: exactly one frame is sent and one `done` pulse occurs.
- `RST` low during the data phase:
  - `k`/`j`/`tx_en`/`busy` go to 0 immediately.
  - No `done` pulse.
  - A new `start` after release produces a complete correct frame.
